// File: rtl/fft_acc_ram_arb.sv
// Two-master arbiter for the FFT accelerator's single-port instruction/data RAM.
// Define FFT_ACC_RAM_ARB_RR_EN for round-robin conflicts; otherwise m0 has fixed priority.
module fft_acc_ram_arb #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  halt,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [DATA_W-1:0]     ram_writedata,
   output logic                  ram_clken,
   input  logic [DATA_W-1:0]     ram_readdata
);

   logic       req0, req1;
   logic       gnt0, gnt1;
   logic [1:0] rd_pend_d, rd_pend_q;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

`ifdef FFT_ACC_RAM_ARB_RR_EN
   // High when m0 took the last accepted transfer; reset low so m0 wins the first conflict.
   logic last_grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b0;
      end else if (gnt0 | gnt1) begin
         last_grant <= gnt0;
      end
   end

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!halt) begin
         if (req0 && req1) begin
            gnt0 = ~last_grant;
            gnt1 = last_grant;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end
`else
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!halt) begin
         gnt0 = req0;
         gnt1 = req1 & ~req0;
      end
   end
`endif

   assign m0_waitrequest = req0 ? ~gnt0 : halt;
   assign m1_waitrequest = req1 ? ~gnt1 : halt;

   // Idle port parks on m0's fields with the write strobe suppressed.
   always_comb begin
      ram_chipselect = gnt0 | gnt1;
      ram_clken      = 1'b1;
      if (gnt1) begin
         ram_address    = m1_address;
         ram_byteenable = m1_byteenable;
         ram_writedata  = m1_writedata;
         ram_write      = m1_write;
      end else begin
         ram_address    = m0_address;
         ram_byteenable = m0_byteenable;
         ram_writedata  = m0_writedata;
         ram_write      = gnt0 & m0_write;
      end
   end

   // A write with read also asserted is a write, so it produces no return.
   assign rd_pend_d = {gnt1 & m1_read & ~m1_write, gnt0 & m0_read & ~m0_write};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend_q <= 2'b00;
      end else begin
         rd_pend_q <= rd_pend_d;
      end
   end

   assign m0_readdatavalid = rd_pend_q[0];
   assign m1_readdatavalid = rd_pend_q[1];
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_fft_acc_ram_arb.sv
// Directed bench for fft_acc_ram_arb with a behavioural 8192x32 RAM on the arbiter's port.
// Expectations follow FFT_ACC_RAM_ARB_RR_EN when defined, fixed priority otherwise.
module tb_fft_acc_ram_arb;

`ifdef FFT_ACC_RAM_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic        clk, reset, halt;
   logic [12:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [12:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [31:0] ram_writedata, ram_readdata;

   int n_vec = 0;
   int n_err = 0;

   fft_acc_ram_arb #(.ADDR_W(13), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .halt(halt),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_writedata(ram_writedata),
      .ram_clken(ram_clken), .ram_readdata(ram_readdata)
   );

   // RAM: registered address, unregistered output.
   logic [31:0] mem [0:8191];
   logic [12:0] ram_addr_q;

   always @(posedge clk) begin
      if (ram_chipselect && ram_clken) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end
         end
         ram_addr_q <= ram_address;
      end
   end
   assign ram_readdata = mem[ram_addr_q];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_m0(input logic rd, input logic wr, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
   endtask

   task automatic set_m1(input logic rd, input logic wr, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
   endtask

   task automatic idle();
      set_m0(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
      set_m1(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
   endtask

   logic        exp_w0, exp_w1, prev0, prev1;
   logic [31:0] pexp;
   int          a0, a1;

   initial begin
      reset = 1'b1;
      halt  = 1'b0;
      idle();
      #12;
      check("rst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
      check("rst_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
      check("rst_cs", {31'b0, ram_chipselect}, 32'd0);
      check("rst_wait0", {31'b0, m0_waitrequest}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Preload m0 region 0x0000.. and m1 region 0x1000..
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         set_m0(1'b0, 1'b1, 13'(k), 4'hF, 32'h1000_0000 + k);
      end
      @(negedge clk);
      set_m0(1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEAD_BEEF);
      #1;
      check("wr_wait0", {31'b0, m0_waitrequest}, 32'd0);
      check("wr_cs", {31'b0, ram_chipselect}, 32'd1);
      check("wr_ramwr", {31'b0, ram_write}, 32'd1);
      @(negedge clk);
      set_m0(1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
      #1;
      check("rd_ramwr", {31'b0, ram_write}, 32'd0);
      @(negedge clk);
      idle();
      #1;
      check("raw_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
      check("raw_data0", m0_readdata, 32'hDEAD_BEEF);
      check("raw_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
      @(negedge clk);
      #1;
      check("raw_once", {31'b0, m0_readdatavalid}, 32'd0);

      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         set_m1(1'b0, 1'b1, 13'h1000 + 13'(k), 4'hF, 32'h2000_0000 + k);
      end
      @(negedge clk);
      set_m1(1'b0, 1'b1, 13'h1FFF, 4'hF, 32'hAAAA_AAAA);
      @(negedge clk);
      set_m1(1'b0, 1'b1, 13'h1FFF, 4'h3, 32'h1122_3344);
      @(negedge clk);
      set_m1(1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
      @(negedge clk);
      idle();
      #1;
      check("be_rdv1", {31'b0, m1_readdatavalid}, 32'd1);
      check("be_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
      check("be_data1", m1_readdata, 32'hAAAA_3344);

      // Continuous contention; m1 won last, so round-robin starts with m0.
      a0 = 0; a1 = 0; prev0 = 1'b0; prev1 = 1'b0; pexp = 32'h0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         set_m0(1'b1, 1'b0, 13'(a0), 4'hF, 32'h0);
         set_m1(1'b1, 1'b0, 13'h1000 + 13'(a1), 4'hF, 32'h0);
         #1;
         exp_w0 = RrEn ? ((c % 2) == 0) : 1'b1;
         exp_w1 = ~exp_w0;
         check("cont_wait0", {31'b0, m0_waitrequest}, {31'b0, ~exp_w0});
         check("cont_wait1", {31'b0, m1_waitrequest}, {31'b0, ~exp_w1});
         check("cont_rdv0", {31'b0, m0_readdatavalid}, {31'b0, prev0});
         check("cont_rdv1", {31'b0, m1_readdatavalid}, {31'b0, prev1});
         if (prev0) check("cont_data0", m0_readdata, pexp);
         if (prev1) check("cont_data1", m1_readdata, pexp);
         prev0 = exp_w0;
         prev1 = exp_w1;
         if (exp_w0) begin
            pexp = 32'h1000_0000 + a0;
            a0++;
         end else begin
            pexp = 32'h2000_0000 + a1;
            a1++;
         end
      end
      @(negedge clk);
      idle();
      #1;
      check("cont_last_rdv0", {31'b0, m0_readdatavalid}, {31'b0, prev0});
      check("cont_last_rdv1", {31'b0, m1_readdatavalid}, {31'b0, prev1});
      if (prev0) check("cont_last_data0", m0_readdata, pexp);
      if (prev1) check("cont_last_data1", m1_readdata, pexp);

      // Read accepted just before halt still returns; halt blocks both masters.
      @(negedge clk);
      set_m0(1'b1, 1'b0, 13'h0001, 4'hF, 32'h0);
      @(negedge clk);
      halt = 1'b1;
      set_m1(1'b1, 1'b0, 13'h1002, 4'hF, 32'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check("halt_wait0", {31'b0, m0_waitrequest}, 32'd1);
         check("halt_wait1", {31'b0, m1_waitrequest}, 32'd1);
         check("halt_cs", {31'b0, ram_chipselect}, 32'd0);
         check("halt_rdv0", {31'b0, m0_readdatavalid}, (c == 0) ? 32'd1 : 32'd0);
         if (c == 0) check("halt_data0", m0_readdata, 32'h1000_0001);
         @(negedge clk);
      end
      halt = 1'b0;
      idle();
      #1;
      check("halt_idle_wait0", {31'b0, m0_waitrequest}, 32'd0);

      // Reset right after an accepted read kills the return and restores m0 priority.
      @(negedge clk);
      set_m0(1'b1, 1'b0, 13'h0002, 4'hF, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle();
      #1;
      check("rst_mid_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
      @(negedge clk);
      check("rst_mid_rdv0_hold", {31'b0, m0_readdatavalid}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      set_m0(1'b1, 1'b0, 13'h0003, 4'hF, 32'h0);
      set_m1(1'b1, 1'b0, 13'h1003, 4'hF, 32'h0);
      #1;
      check("post_rst_wait0", {31'b0, m0_waitrequest}, 32'd0);
      check("post_rst_wait1", {31'b0, m1_waitrequest}, 32'd1);
      @(negedge clk);
      #1;
      check("post_rst_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
      check("post_rst_data0", m0_readdata, 32'h1000_0003);
      check("post_rst2_wait1", {31'b0, m1_waitrequest}, RrEn ? 32'd0 : 32'd1);
      @(negedge clk);
      idle();
      #1;
      check("post_rst2_rdv1", {31'b0, m1_readdatavalid}, RrEn ? 32'd1 : 32'd0);
      if (RrEn) check("post_rst2_data1", m1_readdata, 32'h2000_0003);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fft_acc_ram_arb.md
# fft_acc_ram_arb

Two-master arbiter that shares the single-port 8192×32 instruction/data RAM of the FFT accelerator subsystem between the soft-CPU data master (m0) and the coefficient/program loader DMA (m1). It grants at most one transfer per cycle, drives the RAM's single port, and routes the fixed one-cycle read data back to the master that issued the read, tagged with `readdatavalid`.

## Interface
- `ADDR_W`, 13, word address width (8192 words)
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `clk` in 1 — single clock for arbiter and RAM
- `reset` in 1 — asynchronous, active-high
- `halt` in 1 — when high, no new grants; in-flight read still completes
- `m0_address`, `m1_address` in ADDR_W — word address
- `m0_byteenable`, `m1_byteenable` in DATA_W/8 — write byte lanes
- `m0_read`, `m1_read` in 1 — read request
- `m0_write`, `m1_write` in 1 — write request
- `m0_writedata`, `m1_writedata` in DATA_W — write data
- `m0_waitrequest`, `m1_waitrequest` out 1 — high = request not accepted this cycle
- `m0_readdata`, `m1_readdata` out DATA_W — read return
- `m0_readdatavalid`, `m1_readdatavalid` out 1 — read return strobe
- `ram_address` out ADDR_W, `ram_byteenable` out DATA_W/8, `ram_chipselect` out 1, `ram_write` out 1, `ram_writedata` out DATA_W, `ram_clken` out 1 — RAM port
- `ram_readdata` in DATA_W — RAM output (address registered, output unregistered)

## Operation
- Request of master i: `mi_read | mi_write`. If both are asserted, the request is treated as a write and the read is ignored.
- Arbitration is combinational each cycle:
  - Neither master requests, or `halt`: no grant.
  - One master requests: that master is granted.
  - Both request: grant goes to the master that was *not* the last winner.
- `last_grant` register:
  - Reset value 0 (m0 wins first conflict).
  - Updates to the winner only when a transfer is accepted.
- Granted master: `mi_waitrequest`=0 in the same cycle. Losing or idle master: `mi_waitrequest`=1 whenever it requests.
  - Non-requesting master's waitrequest equals `halt`.
- RAM port drive:
  - `ram_chipselect` = grant valid.
  - Address, byteenable and writedata are muxed from the winner.
  - `ram_write` = winner's write.
  - `ram_clken` = 1 constantly.
  - With no grant, the mux selects m0 fields and `ram_write`=0.
- Read tag:
  - Register `rd_pend`[1:0]: one-hot of the master whose read was accepted in the previous cycle; 0 otherwise.
  - `mi_readdatavalid` = `rd_pend[i]`.
  - `mi_readdata` = `ram_readdata` for both masters (unqualified outside valid).
- Writes produce no response; write data is committed at the accepting edge.
- Read-after-write to the same address on consecutive cycles returns the new data. Same-cycle conflicts cannot occur (single port).

## Timing
- Accepted read in cycle N → `mi_readdatavalid`=1 with data in cycle N+1, exactly one cycle.
- Back-to-back reads by one master, one per cycle, are supported. Alternating winners under contention give each master one transfer per 2 cycles.
- Maximum wait for a requesting master with `halt`=0 is 1 cycle.
- `halt` asserted in cycle N: no acceptance in N. A read accepted in N-1 still returns in N.
- Reset values:
  - `rd_pend`=0, so both readdatavalid=0.
  - `last_grant`=0.
  - `ram_chipselect`=0 while inputs are idle.
  - Combinational outputs follow their inputs.
- Reset asserted mid-read: the pending readdatavalid is cleared immediately (async) and never issued.

## Configuration
- `FFT_ACC_RAM_ARB_RR_EN`:
  - Defined: round-robin arbitration as described.
  - Undefined: fixed priority; m0 always wins a conflict, `last_grant` is not implemented, and m1 can starve under continuous m0 traffic.

## Test plan
- Reset, then m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF; next cycle m0 reads 0x0010 → m0_readdatavalid=1 one cycle later, m0_readdata=0xDEADBEEF, m1_readdatavalid=0.
- Both masters read continuously: m0 from 0x0000.., m1 from 0x1000.. → grants alternate m0,m1,m0…, each master's waitrequest low every other cycle, every readdatavalid routed to the correct master with the matching data.
- m1 writes 0x11223344 to 0x1FFF with byteenable 0x3 over a prior value 0xAAAAAAAA → read returns 0xAAAA3344.
- `halt` held high for 3 cycles with both requesting → both waitrequests high and no ram_chipselect; a read accepted the cycle before `halt` still returns valid.
- Reset asserted in the cycle after an accepted read → no readdatavalid; after release, first conflict is granted to m0.
- Build without `FFT_ACC_RAM_ARB_RR_EN`, both masters requesting for 4 cycles → m0 granted all 4, m1_waitrequest=1 throughout.
